// File: rtl/pkt_deframer.sv
// Byte-stream packet deframer: checks the header and tail around each payload and
// repacks the payload bytes LSB-first into 32-bit words with sop/eop/mty.
module pkt_deframer #(
   parameter logic [7:0] PRE       = 8'h55,
   parameter logic [7:0] HSFD      = 8'hD5,
   parameter logic [7:0] TSFD      = 8'hFD,
   parameter bit         CHECK_SEQ = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  din,
   input  logic        din_vld,
   input  logic        din_sop,
   input  logic        din_eop,
   output logic [31:0] dout,
   output logic        dout_vld,
   output logic        dout_sop,
   output logic        dout_eop,
   output logic [1:0]  dout_mty,
   output logic [7:0]  pkt_id,
   output logic        pkt_done,
   output logic        pkt_ok,
   output logic        err_hdr,
   output logic        err_tail,
   output logic        err_seq,
   output logic        err_fmt
);

   typedef enum logic [2:0] {IDLE, HEAD, WDATA, DATA, WTAIL, TAIL, DROP} state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [7:0]  exp_id_q, exp_id_d;
   logic [7:0]  pkt_id_q, pkt_id_d;
   logic        bad_q, bad_d;
   logic [31:0] buf_q, buf_d;
   logic [1:0]  nb_q, nb_d;
   logic        first_q, first_d;
   logic [31:0] dout_q, dout_d;
   logic        dout_vld_q, dout_vld_d;
   logic        dout_sop_q, dout_sop_d;
   logic        dout_eop_q, dout_eop_d;
   logic [1:0]  dout_mty_q, dout_mty_d;
   logic        pkt_done_q, pkt_done_d;
   logic        pkt_ok_q, pkt_ok_d;
   logic        err_hdr_q, err_hdr_d;
   logic        err_tail_q, err_tail_d;
   logic        err_seq_q, err_seq_d;
   logic        err_fmt_q, err_fmt_d;

   logic        hdr_start, hdr_byte, hdr_match, hdr_bad;
   logic [2:0]  hdr_idx;
   logic        data_byte, sop_cur;
   logic [1:0]  nb_cur;
   logic [31:0] buf_cur, word;
   logic        tail_byte, tail_match, tail_viol;
   logic [2:0]  tail_idx;

   // Any sop outside WDATA/WTAIL starts a fresh header; that byte is header byte 0.
   assign hdr_start = din_vld && din_sop &&
                      (state_q inside {IDLE, HEAD, DATA, TAIL, DROP});
   assign hdr_byte  = hdr_start || (din_vld && !din_sop && state_q == HEAD);
   assign hdr_idx   = hdr_start ? 3'd0 : cnt_q;
   assign hdr_match = (hdr_idx < 3'd3) ? (din == PRE) :
                      (hdr_idx < 3'd5) ? (din == HSFD) : 1'b1;
   assign hdr_bad   = !hdr_match || (din_eop != (hdr_idx == 3'd5));

   assign data_byte = din_vld && ((state_q == WDATA && din_sop) ||
                                  (state_q == DATA && !din_sop));
   assign nb_cur    = (state_q == WDATA) ? 2'd0 : nb_q;
   assign buf_cur   = (state_q == WDATA) ? 32'd0 : buf_q;
   assign sop_cur   = (state_q == WDATA) ? 1'b1 : first_q;
   assign word      = buf_cur | ({24'd0, din} << {nb_cur, 3'b000});

   assign tail_byte  = din_vld && ((state_q == WTAIL && din_sop) ||
                                   (state_q == TAIL && !din_sop));
   assign tail_idx   = (state_q == WTAIL) ? 3'd0 : cnt_q;
   assign tail_match = (tail_idx < 3'd3) ? (din == PRE) :
                       (tail_idx < 3'd5) ? (din == TSFD) : (din == pkt_id_q);
   assign tail_viol  = !tail_match || (din_eop != (tail_idx == 3'd5));

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      exp_id_d   = exp_id_q;
      pkt_id_d   = pkt_id_q;
      bad_d      = bad_q;
      buf_d      = buf_q;
      nb_d       = nb_q;
      first_d    = first_q;
      dout_d     = 32'd0;
      dout_vld_d = 1'b0;
      dout_sop_d = 1'b0;
      dout_eop_d = 1'b0;
      dout_mty_d = 2'd0;
      pkt_done_d = 1'b0;
      pkt_ok_d   = 1'b0;
      err_hdr_d  = 1'b0;
      err_tail_d = 1'b0;
      err_seq_d  = 1'b0;
      err_fmt_d  = 1'b0;

      if (hdr_byte) begin
         if (hdr_start) begin
            bad_d = 1'b0;
            if (state_q != IDLE) err_fmt_d = 1'b1;
            // Payload cut short by a new sop: flush what is held as the eop word.
            if (state_q == DATA) begin
               dout_d     = buf_q;
               dout_vld_d = 1'b1;
               dout_sop_d = first_q;
               dout_eop_d = 1'b1;
               dout_mty_d = (nb_q == 2'd0) ? 2'd3 : 2'd0 - nb_q;
               buf_d      = 32'd0;
               nb_d       = 2'd0;
               first_d    = 1'b0;
            end
         end
         if (hdr_bad) begin
            err_hdr_d = 1'b1;
            state_d   = din_eop ? IDLE : DROP;
         end else if (hdr_idx == 3'd5) begin
            pkt_id_d = din;
            exp_id_d = din + 8'd1;
            if (CHECK_SEQ && din != exp_id_q) begin
               err_seq_d = 1'b1;
               bad_d     = 1'b1;
            end
            state_d = WDATA;
         end else begin
            state_d = HEAD;
            cnt_d   = hdr_idx + 3'd1;
         end
      end else if (data_byte) begin
         if (nb_cur == 2'd3 || din_eop) begin
            dout_d     = word;
            dout_vld_d = 1'b1;
            dout_sop_d = sop_cur;
            dout_eop_d = din_eop;
            dout_mty_d = din_eop ? 2'd3 - nb_cur : 2'd0;
            buf_d      = 32'd0;
            nb_d       = 2'd0;
            first_d    = 1'b0;
         end else begin
            buf_d   = word;
            nb_d    = nb_cur + 2'd1;
            first_d = sop_cur;
         end
         state_d = din_eop ? WTAIL : DATA;
      end else if (tail_byte) begin
         if (tail_viol) begin
            err_tail_d = 1'b1;
            bad_d      = 1'b1;
         end
         if (din_eop) begin
            state_d = IDLE;
            if (tail_idx == 3'd5) begin
               pkt_done_d = 1'b1;
               pkt_ok_d   = !(bad_q || tail_viol);
            end
         end else if (tail_idx == 3'd5) begin
            state_d = DROP;
         end else begin
            state_d = TAIL;
            cnt_d   = tail_idx + 3'd1;
         end
      end else if (din_vld && state_q == DROP) begin
         if (din_eop) state_d = IDLE;
      end else if (din_vld) begin
         // Stray byte without sop in IDLE, WDATA or WTAIL.
         err_fmt_d = 1'b1;
         if (state_q == WTAIL) bad_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= 3'd0;
         exp_id_q   <= 8'd0;
         pkt_id_q   <= 8'd0;
         bad_q      <= 1'b0;
         buf_q      <= 32'd0;
         nb_q       <= 2'd0;
         first_q    <= 1'b0;
         dout_q     <= 32'd0;
         dout_vld_q <= 1'b0;
         dout_sop_q <= 1'b0;
         dout_eop_q <= 1'b0;
         dout_mty_q <= 2'd0;
         pkt_done_q <= 1'b0;
         pkt_ok_q   <= 1'b0;
         err_hdr_q  <= 1'b0;
         err_tail_q <= 1'b0;
         err_seq_q  <= 1'b0;
         err_fmt_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         exp_id_q   <= exp_id_d;
         pkt_id_q   <= pkt_id_d;
         bad_q      <= bad_d;
         buf_q      <= buf_d;
         nb_q       <= nb_d;
         first_q    <= first_d;
         dout_q     <= dout_d;
         dout_vld_q <= dout_vld_d;
         dout_sop_q <= dout_sop_d;
         dout_eop_q <= dout_eop_d;
         dout_mty_q <= dout_mty_d;
         pkt_done_q <= pkt_done_d;
         pkt_ok_q   <= pkt_ok_d;
         err_hdr_q  <= err_hdr_d;
         err_tail_q <= err_tail_d;
         err_seq_q  <= err_seq_d;
         err_fmt_q  <= err_fmt_d;
      end
   end

   assign dout     = dout_q;
   assign dout_vld = dout_vld_q;
   assign dout_sop = dout_sop_q;
   assign dout_eop = dout_eop_q;
   assign dout_mty = dout_mty_q;
   assign pkt_id   = pkt_id_q;
   assign pkt_done = pkt_done_q;
   assign pkt_ok   = pkt_ok_q;
   assign err_hdr  = err_hdr_q;
   assign err_tail = err_tail_q;
   assign err_seq  = err_seq_q;
   assign err_fmt  = err_fmt_q;

endmodule

// File: tb/tb_pkt_deframer.sv
// Directed bench for pkt_deframer: packets are driven byte by byte and the decoded
// words, completion flags and error pulses are collected and compared per scenario.
module tb_pkt_deframer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  din;
   logic        din_vld, din_sop, din_eop;
   logic [31:0] dout;
   logic        dout_vld, dout_sop, dout_eop;
   logic [1:0]  dout_mty;
   logic [7:0]  pkt_id;
   logic        pkt_done, pkt_ok, err_hdr, err_tail, err_seq, err_fmt;

   always #5 clk = ~clk;

   pkt_deframer dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_sop(din_sop),
      .din_eop(din_eop), .dout(dout), .dout_vld(dout_vld), .dout_sop(dout_sop),
      .dout_eop(dout_eop), .dout_mty(dout_mty), .pkt_id(pkt_id), .pkt_done(pkt_done),
      .pkt_ok(pkt_ok), .err_hdr(err_hdr), .err_tail(err_tail), .err_seq(err_seq),
      .err_fmt(err_fmt)
   );

   typedef struct packed {
      logic [31:0] d;
      logic        s;
      logic        e;
      logic [1:0]  m;
   } word_t;

   word_t      wq[$];
   word_t      ew[$];
   bit         okq[$];
   logic [7:0] seg[$];
   int         n_hdr, n_tail, n_seq, n_fmt;
   int         total = 0;
   int         bad = 0;

   // Collector: records every output event, sampled mid-cycle.
   always @(negedge clk) begin
      if (dout_vld === 1'b1) wq.push_back({dout, dout_sop, dout_eop, dout_mty});
      if (pkt_done === 1'b1) okq.push_back(pkt_ok);
      if (err_hdr === 1'b1) n_hdr = n_hdr + 1;
      if (err_tail === 1'b1) n_tail = n_tail + 1;
      if (err_seq === 1'b1) n_seq = n_seq + 1;
      if (err_fmt === 1'b1) n_fmt = n_fmt + 1;
   end

   task automatic clr();
      wq.delete(); ew.delete(); okq.delete();
      n_hdr = 0; n_tail = 0; n_seq = 0; n_fmt = 0;
   endtask

   task automatic drv(input logic [7:0] b, input logic s, input logic e);
      @(negedge clk);
      din = b; din_vld = 1'b1; din_sop = s; din_eop = e;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
      end
   endtask

   task automatic send_seg(input bit gaps, input bit with_eop);
      foreach (seg[i]) begin
         drv(seg[i], i == 0, with_eop && (i == seg.size() - 1));
         if (gaps) idle(1);
      end
   endtask

   task automatic mk_hdr(input logic [7:0] id);
      seg = {8'h55, 8'h55, 8'h55, 8'hD5, 8'hD5, id};
   endtask

   task automatic mk_tail(input logic [7:0] id);
      seg = {8'h55, 8'h55, 8'h55, 8'hFD, 8'hFD, id};
   endtask

   task automatic mk_pay(input logic [7:0] base, input int len);
      seg.delete();
      for (int i = 0; i < len; i++) seg.push_back(base + 8'(i));
   endtask

   task automatic send_pkt(input logic [7:0] hid, input logic [7:0] base, input int len,
                           input logic [7:0] tid, input bit gaps);
      mk_hdr(hid);       send_seg(gaps, 1'b1);
      mk_pay(base, len); send_seg(gaps, 1'b1);
      mk_tail(tid);      send_seg(gaps, 1'b1);
   endtask

   task automatic test_reset();
      rst_n = 1'b1; din = 8'd0; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({dout, dout_vld, dout_sop, dout_eop, dout_mty, pkt_done, pkt_ok} !== 39'd0) begin
         bad++; $display("FAIL reset_dout got=%h vld=%b want=0", dout, dout_vld);
      end
      total++;
      if ({pkt_id, err_hdr, err_tail, err_seq, err_fmt} !== 12'd0) begin
         bad++; $display("FAIL reset_flags got=%h want=000",
                         {pkt_id, err_hdr, err_tail, err_seq, err_fmt});
      end
      rst_n = 1'b0;
      idle(2);
   endtask

   task automatic test_basic();
      word_t got;
      clr();
      send_pkt(8'h00, 8'h11, 5, 8'h00, 1'b0);
      idle(3);
      ew.push_back({32'h14131211, 1'b1, 1'b0, 2'd0});
      ew.push_back({32'h00000015, 1'b0, 1'b1, 2'd3});
      total++;
      if (wq.size() != ew.size()) begin bad++; $display("FAIL basic_nwords got=%0d want=%0d", wq.size(), ew.size()); end
      foreach (ew[i]) begin
         got = '1; if (i < wq.size()) got = wq[i];
         total++;
         if (got !== ew[i]) begin bad++; $display("FAIL basic_word%0d got=%h want=%h", i, got, ew[i]); end
      end
      total++;
      if (okq.size() != 1) begin bad++; $display("FAIL basic_done got=%0d pulses want=1", okq.size()); end
      else if (okq[0] !== 1'b1) begin bad++; $display("FAIL basic_ok got=0 want=1"); end
      total++;
      if (n_hdr + n_tail + n_seq + n_fmt != 0) begin
         bad++; $display("FAIL basic_errs got=%0d want=0", n_hdr + n_tail + n_seq + n_fmt);
      end
   endtask

   task automatic test_gaps();
      word_t got;
      rst_n = 1'b1; idle(2); rst_n = 1'b0; idle(1);
      clr();
      send_pkt(8'h00, 8'h11, 5, 8'h00, 1'b1);
      send_pkt(8'h01, 8'h21, 8, 8'h01, 1'b0);
      idle(3);
      ew.push_back({32'h14131211, 1'b1, 1'b0, 2'd0});
      ew.push_back({32'h00000015, 1'b0, 1'b1, 2'd3});
      ew.push_back({32'h24232221, 1'b1, 1'b0, 2'd0});
      ew.push_back({32'h28272625, 1'b0, 1'b1, 2'd0});
      total++;
      if (wq.size() != ew.size()) begin bad++; $display("FAIL gaps_nwords got=%0d want=%0d", wq.size(), ew.size()); end
      foreach (ew[i]) begin
         got = '1; if (i < wq.size()) got = wq[i];
         total++;
         if (got !== ew[i]) begin bad++; $display("FAIL gaps_word%0d got=%h want=%h", i, got, ew[i]); end
      end
      total++;
      if (okq.size() != 2) begin bad++; $display("FAIL gaps_done got=%0d pulses want=2", okq.size()); end
      else if (okq[0] !== 1'b1 || okq[1] !== 1'b1) begin bad++; $display("FAIL gaps_ok got=%b%b want=11", okq[0], okq[1]); end
      total++;
      if (pkt_id !== 8'h01) begin bad++; $display("FAIL gaps_pkt_id got=%h want=01", pkt_id); end
      total++;
      if (n_seq != 0) begin bad++; $display("FAIL gaps_err_seq got=%0d want=0", n_seq); end
   endtask

   task automatic test_seq_err();
      clr();
      send_pkt(8'h05, 8'h31, 3, 8'h05, 1'b0);
      idle(3);
      total++;
      if (n_seq != 1) begin bad++; $display("FAIL seq_err_seq got=%0d want=1", n_seq); end
      total++;
      if (wq.size() != 1) begin bad++; $display("FAIL seq_nwords got=%0d want=1", wq.size()); end
      else if (wq[0] !== {32'h00333231, 1'b1, 1'b1, 2'd1}) begin
         bad++; $display("FAIL seq_word got=%h want=%h", wq[0], {32'h00333231, 1'b1, 1'b1, 2'd1});
      end
      total++;
      if (okq.size() != 1) begin bad++; $display("FAIL seq_done got=%0d pulses want=1", okq.size()); end
      else if (okq[0] !== 1'b0) begin bad++; $display("FAIL seq_ok got=1 want=0"); end
      total++;
      if (pkt_id !== 8'h05) begin bad++; $display("FAIL seq_pkt_id got=%h want=05", pkt_id); end
   endtask

   task automatic test_tail_err();
      clr();
      send_pkt(8'h06, 8'h41, 2, 8'h07, 1'b0);
      idle(3);
      total++;
      if (n_seq != 0) begin bad++; $display("FAIL tail_err_seq got=%0d want=0", n_seq); end
      total++;
      if (n_tail != 1) begin bad++; $display("FAIL tail_err_tail got=%0d want=1", n_tail); end
      total++;
      if (wq.size() != 1) begin bad++; $display("FAIL tail_nwords got=%0d want=1", wq.size()); end
      else if (wq[0] !== {32'h00004241, 1'b1, 1'b1, 2'd2}) begin
         bad++; $display("FAIL tail_word got=%h want=%h", wq[0], {32'h00004241, 1'b1, 1'b1, 2'd2});
      end
      total++;
      if (okq.size() != 1) begin bad++; $display("FAIL tail_done got=%0d pulses want=1", okq.size()); end
      else if (okq[0] !== 1'b0) begin bad++; $display("FAIL tail_ok got=1 want=0"); end
   endtask

   task automatic test_hdr_err();
      clr();
      seg = {8'h55, 8'h55, 8'h55, 8'hD4, 8'hD5, 8'h07};
      send_seg(1'b0, 1'b1);
      mk_pay(8'h51, 4); send_seg(1'b0, 1'b1);
      mk_tail(8'h07);   send_seg(1'b0, 1'b1);
      idle(3);
      drv(8'h99, 1'b0, 1'b0);
      idle(3);
      total++;
      if (n_hdr != 3) begin bad++; $display("FAIL hdr_err_hdr got=%0d want=3", n_hdr); end
      total++;
      if (n_fmt != 1) begin bad++; $display("FAIL hdr_err_fmt got=%0d want=1", n_fmt); end
      total++;
      if (wq.size() != 0 || okq.size() != 0) begin
         bad++; $display("FAIL hdr_no_output got words=%0d done=%0d want 0/0", wq.size(), okq.size());
      end
      total++;
      if (n_tail != 0) begin bad++; $display("FAIL hdr_err_tail got=%0d want=0", n_tail); end
   endtask

   task automatic test_single_byte();
      clr();
      mk_hdr(8'h07); send_seg(1'b0, 1'b1);
      drv(8'hAA, 1'b1, 1'b1);
      @(negedge clk);
      din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
      total++;
      if ({dout_vld, dout, dout_sop, dout_eop, dout_mty} !== {1'b1, 32'h000000AA, 1'b1, 1'b1, 2'd3}) begin
         bad++; $display("FAIL single_word got vld=%b d=%h s=%b e=%b m=%0d want 1/000000aa/1/1/3",
                         dout_vld, dout, dout_sop, dout_eop, dout_mty);
      end
      mk_tail(8'h07); send_seg(1'b0, 1'b1);
      idle(3);
      total++;
      if (okq.size() != 1) begin bad++; $display("FAIL single_done got=%0d pulses want=1", okq.size()); end
      else if (okq[0] !== 1'b1) begin bad++; $display("FAIL single_ok got=0 want=1"); end
      total++;
      if (n_seq + n_tail + n_hdr + n_fmt != 0 || wq.size() != 1) begin
         bad++; $display("FAIL single_clean got errs=%0d words=%0d want 0/1", n_seq + n_tail + n_hdr + n_fmt, wq.size());
      end
   endtask

   task automatic test_reset_mid();
      word_t got;
      clr();
      mk_hdr(8'h08); send_seg(1'b0, 1'b1);
      drv(8'h81, 1'b1, 1'b0);
      drv(8'h82, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
      @(negedge clk); @(negedge clk);
      total++;
      if ({dout, dout_vld, dout_sop, dout_eop, dout_mty, pkt_id, pkt_done, pkt_ok,
           err_hdr, err_tail, err_seq, err_fmt} !== 51'd0) begin
         bad++; $display("FAIL midrst_outputs got vld=%b pkt_id=%h want all 0", dout_vld, pkt_id);
      end
      rst_n = 1'b0;
      idle(2);
      clr();
      send_pkt(8'h00, 8'h81, 6, 8'h00, 1'b0);
      idle(3);
      ew.push_back({32'h84838281, 1'b1, 1'b0, 2'd0});
      ew.push_back({32'h00008685, 1'b0, 1'b1, 2'd2});
      total++;
      if (wq.size() != ew.size()) begin bad++; $display("FAIL midrst_nwords got=%0d want=%0d", wq.size(), ew.size()); end
      foreach (ew[i]) begin
         got = '1; if (i < wq.size()) got = wq[i];
         total++;
         if (got !== ew[i]) begin bad++; $display("FAIL midrst_word%0d got=%h want=%h", i, got, ew[i]); end
      end
      total++;
      if (n_seq != 0) begin bad++; $display("FAIL midrst_err_seq got=%0d want=0", n_seq); end
      total++;
      if (okq.size() != 1) begin bad++; $display("FAIL midrst_done got=%0d pulses want=1", okq.size()); end
      else if (okq[0] !== 1'b1) begin bad++; $display("FAIL midrst_ok got=0 want=1"); end
   endtask

   task automatic test_abort();
      word_t got;
      clr();
      mk_hdr(8'h01);     send_seg(1'b0, 1'b1);
      mk_pay(8'h61, 5);  send_seg(1'b0, 1'b0);
      mk_hdr(8'h02);     send_seg(1'b0, 1'b1);
      seg = {8'h71};     send_seg(1'b0, 1'b1);
      mk_tail(8'h02);    send_seg(1'b0, 1'b1);
      idle(3);
      ew.push_back({32'h64636261, 1'b1, 1'b0, 2'd0});
      ew.push_back({32'h00000065, 1'b0, 1'b1, 2'd3});
      ew.push_back({32'h00000071, 1'b1, 1'b1, 2'd3});
      total++;
      if (wq.size() != ew.size()) begin bad++; $display("FAIL abort_nwords got=%0d want=%0d", wq.size(), ew.size()); end
      foreach (ew[i]) begin
         got = '1; if (i < wq.size()) got = wq[i];
         total++;
         if (got !== ew[i]) begin bad++; $display("FAIL abort_word%0d got=%h want=%h", i, got, ew[i]); end
      end
      total++;
      if (n_fmt != 1) begin bad++; $display("FAIL abort_err_fmt got=%0d want=1", n_fmt); end
      total++;
      if (n_hdr + n_seq + n_tail != 0) begin bad++; $display("FAIL abort_errs got=%0d want=0", n_hdr + n_seq + n_tail); end
      total++;
      if (okq.size() != 1) begin bad++; $display("FAIL abort_done got=%0d pulses want=1", okq.size()); end
      else if (okq[0] !== 1'b1) begin bad++; $display("FAIL abort_ok got=0 want=1"); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      n_hdr = 0; n_tail = 0; n_seq = 0; n_fmt = 0;
      test_reset();
      test_basic();
      test_gaps();
      test_seq_err();
      test_tail_err();
      test_hdr_err();
      test_single_byte();
      test_reset_mid();
      test_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
